// File: rtl/path_accum_filter.sv
// Windowed, saturating accumulator of path counts from request lanes whose node matches a latched target.
// The result is held on a valid/ready handshake until downstream accepts it.
module path_accum_filter #(
    parameter int NUM_REQ       = 8,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int NODE_WIDTH    = 12,
    parameter int ACC_WIDTH     = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [NODE_WIDTH-1:0]    i_target_node,
    input  logic [NUM_REQ-1:0]       i_req_vld,
    input  logic [PAYLOAD_WIDTH-1:0] i_req_paths   [NUM_REQ],
    input  logic [NODE_WIDTH-1:0]    i_req_nodenum [NUM_REQ],
    output logic                     o_req_rdy,
    input  logic                     i_done,
    output logic                     o_acc_vld,
    input  logic                     i_acc_rdy,
    output logic [ACC_WIDTH-1:0]     o_acc_paths,
    output logic [CNT_WIDTH-1:0]     o_acc_count,
    output logic                     o_acc_sat,
    output logic                     o_busy
);

    // Extended widths leave one spare bit above the larger operand so an overflow is always visible.
    localparam int SUM_W     = PAYLOAD_WIDTH + $clog2(NUM_REQ);
    localparam int ACC_EXT_W = ((SUM_W > ACC_WIDTH) ? SUM_W : ACC_WIDTH) + 1;
    localparam int POP_W     = $clog2(NUM_REQ + 1);
    localparam int CNT_EXT_W = ((POP_W > CNT_WIDTH) ? POP_W : CNT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic [NODE_WIDTH-1:0]  target_q, target_d;
    logic [ACC_WIDTH-1:0]   paths_q,  paths_d;
    logic [CNT_WIDTH-1:0]   count_q,  count_d;
    logic                   sat_q,    sat_d;

    logic [ACC_EXT_W-1:0]   laneSum;
    logic [ACC_EXT_W-1:0]   pathsExt;
    logic [CNT_EXT_W-1:0]   laneCount;
    logic [CNT_EXT_W-1:0]   countExt;
    logic                   pathsOvf;
    logic                   countOvf;

    always_comb begin
        laneSum   = '0;
        laneCount = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_vld[k] && (i_req_nodenum[k] == target_q)) begin
                laneSum   = laneSum + ACC_EXT_W'(i_req_paths[k]);
                laneCount = laneCount + CNT_EXT_W'(1);
            end
        end
        pathsExt = ACC_EXT_W'(paths_q) + laneSum;
        countExt = CNT_EXT_W'(count_q) + laneCount;
        pathsOvf = |pathsExt[ACC_EXT_W-1:ACC_WIDTH];
        countOvf = |countExt[CNT_EXT_W-1:CNT_WIDTH];
    end

    // A start in ACCUM takes priority over a same-cycle done and discards that cycle's lanes.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        paths_d  = paths_q;
        count_d  = count_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = ACCUM;
                    target_d = i_target_node;
                    paths_d  = '0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                end
            end
            ACCUM: begin
                if (i_start) begin
                    target_d = i_target_node;
                    paths_d  = '0;
                    count_d  = '0;
                    sat_d    = 1'b0;
                end else begin
                    paths_d = pathsOvf ? '1 : pathsExt[ACC_WIDTH-1:0];
                    count_d = countOvf ? '1 : countExt[CNT_WIDTH-1:0];
                    sat_d   = sat_q | pathsOvf | countOvf;
                    if (i_done) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (i_acc_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            paths_q  <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            paths_q  <= paths_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
        end
    end

    assign o_req_rdy   = (state_q == ACCUM);
    assign o_acc_vld   = (state_q == OUT);
    assign o_busy      = (state_q != IDLE);
    assign o_acc_paths = paths_q;
    assign o_acc_count = count_q;
    assign o_acc_sat   = sat_q;

endmodule

// File: tb/tb_path_accum_filter.sv
// Directed plus randomized bench for path_accum_filter: a default build and a narrow build (17-bit paths,
// 4-bit count) share all inputs and are both checked against an unbounded-sum reference with clamp-on-read.
module tb_path_accum_filter;

    localparam int NUM_REQ = 8;
    localparam int PW      = 16;
    localparam int NW      = 12;

    localparam longint W_PMAX = 64'hFFFF_FFFF;
    localparam longint W_CMAX = 65535;
    localparam longint N_PMAX = 131071;
    localparam longint N_CMAX = 15;

    logic          clk;
    logic          rstN;
    logic          start;
    logic          done;
    logic          accRdy;
    logic [NW-1:0] targetNode;
    logic [NUM_REQ-1:0] reqVld;
    logic [PW-1:0] reqPaths [NUM_REQ];
    logic [NW-1:0] reqNode  [NUM_REQ];

    logic        rdyW, vldW, satW, busyW;
    logic [31:0] pathsW;
    logic [15:0] countW;
    logic        rdyN, vldN, satN, busyN;
    logic [16:0] pathsN;
    logic [3:0]  countN;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: window/result flags plus an unbounded running sum and count.
    bit            mOpen;
    bit            mPending;
    longint        mSum;
    longint        mCnt;
    logic [NW-1:0] mTarget;

    path_accum_filter dutWide (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_target_node(targetNode),
        .i_req_vld(reqVld), .i_req_paths(reqPaths), .i_req_nodenum(reqNode),
        .o_req_rdy(rdyW), .i_done(done), .o_acc_vld(vldW), .i_acc_rdy(accRdy),
        .o_acc_paths(pathsW), .o_acc_count(countW), .o_acc_sat(satW), .o_busy(busyW)
    );

    path_accum_filter #(.ACC_WIDTH(17), .CNT_WIDTH(4)) dutNarrow (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_target_node(targetNode),
        .i_req_vld(reqVld), .i_req_paths(reqPaths), .i_req_nodenum(reqNode),
        .o_req_rdy(rdyN), .i_done(done), .o_acc_vld(vldN), .i_acc_rdy(accRdy),
        .o_acc_paths(pathsN), .o_acc_count(countN), .o_acc_sat(satN), .o_busy(busyN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] clampTo(input longint v, input longint mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    task automatic checkOutput(input string phase);
        checkVal({phase, ".w.rdy"},   64'(rdyW),   64'(mOpen));
        checkVal({phase, ".w.vld"},   64'(vldW),   64'(mPending));
        checkVal({phase, ".w.busy"},  64'(busyW),  64'(mOpen | mPending));
        checkVal({phase, ".w.paths"}, 64'(pathsW), clampTo(mSum, W_PMAX));
        checkVal({phase, ".w.count"}, 64'(countW), clampTo(mCnt, W_CMAX));
        checkVal({phase, ".w.sat"},   64'(satW),   64'((mSum > W_PMAX) || (mCnt > W_CMAX)));
        checkVal({phase, ".n.rdy"},   64'(rdyN),   64'(mOpen));
        checkVal({phase, ".n.vld"},   64'(vldN),   64'(mPending));
        checkVal({phase, ".n.busy"},  64'(busyN),  64'(mOpen | mPending));
        checkVal({phase, ".n.paths"}, 64'(pathsN), clampTo(mSum, N_PMAX));
        checkVal({phase, ".n.count"}, 64'(countN), clampTo(mCnt, N_CMAX));
        checkVal({phase, ".n.sat"},   64'(satN),   64'((mSum > N_PMAX) || (mCnt > N_CMAX)));
    endtask

    task automatic modelReset();
        mOpen    = 1'b0;
        mPending = 1'b0;
        mSum     = 0;
        mCnt     = 0;
        mTarget  = '0;
    endtask

    task automatic modelStep();
        if (mOpen) begin
            if (start) begin
                mTarget = targetNode;
                mSum    = 0;
                mCnt    = 0;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (reqVld[k] && (reqNode[k] == mTarget)) begin
                        mSum += longint'(reqPaths[k]);
                        mCnt += 1;
                    end
                end
                if (done) begin
                    mOpen    = 1'b0;
                    mPending = 1'b1;
                end
            end
        end else if (mPending) begin
            if (accRdy) mPending = 1'b0;
        end else if (start) begin
            mTarget = targetNode;
            mSum    = 0;
            mCnt    = 0;
            mOpen   = 1'b1;
        end
    endtask

    task automatic clearLanes();
        reqVld = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            reqPaths[k] = '0;
            reqNode[k]  = '0;
        end
    endtask

    task automatic setAllLanes(input logic [NW-1:0] node, input logic [PW-1:0] paths);
        reqVld = '1;
        for (int k = 0; k < NUM_REQ; k++) begin
            reqPaths[k] = paths;
            reqNode[k]  = node;
        end
    endtask

    task automatic randomLanes(input logic [NW-1:0] tgt);
        for (int k = 0; k < NUM_REQ; k++) begin
            reqVld[k]   = 1'($urandom_range(0, 1));
            reqNode[k]  = ($urandom_range(0, 3) == 0) ? (tgt ^ 12'h001) : tgt;
            reqPaths[k] = 16'($urandom);
        end
    endtask

    // Drives one cycle of control inputs, advances the reference across the edge, then checks.
    task automatic applyStimulus(input bit s, input logic [NW-1:0] t, input bit d, input bit r,
                                 input string phase);
        start      = s;
        targetNode = t;
        done       = d;
        accRdy     = r;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(phase);
    endtask

    task automatic doReset(input string phase);
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput({phase, ".async"});
        @(posedge clk);
        #1;
        checkOutput({phase, ".hold"});
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0;
        start = 1'b0; done = 1'b0; accRdy = 1'b0; targetNode = '0;
        clearLanes();
        modelReset();

        // 1: basic match with a non-matching valid lane, then held result.
        doReset("t1.rst");
        applyStimulus(1, 12'h005, 0, 0, "t1.start");
        reqVld[2] = 1'b1; reqNode[2] = 12'h005; reqPaths[2] = 16'd3;
        reqVld[6] = 1'b1; reqNode[6] = 12'h005; reqPaths[6] = 16'd7;
        reqVld[4] = 1'b1; reqNode[4] = 12'h006; reqPaths[4] = 16'd100;
        applyStimulus(0, 12'h000, 0, 0, "t1.lanes");
        clearLanes();
        applyStimulus(0, 12'h000, 1, 0, "t1.done");
        checkVal("t1.paths10", 64'(pathsW), 64'd10);
        checkVal("t1.count2",  64'(countW), 64'd2);
        for (int c = 0; c < 3; c++) applyStimulus(0, 12'h000, 0, 0, "t1.hold");
        applyStimulus(0, 12'h000, 0, 1, "t1.accept");

        // 2/3: all lanes at 0xFFFF; the narrow build clamps both paths and count.
        applyStimulus(1, 12'h0FF, 0, 0, "t2.start");
        setAllLanes(12'h0FF, 16'hFFFF);
        for (int c = 0; c < 3; c++) applyStimulus(0, 12'h000, 0, 0, "t2.lanes");
        applyStimulus(0, 12'h000, 1, 0, "t2.done");
        checkVal("t2.wpaths", 64'(pathsW), 64'h1FFFE0);
        checkVal("t2.wcount", 64'(countW), 64'd32);
        checkVal("t2.npaths", 64'(pathsN), 64'h1FFFF);
        checkVal("t2.nsat",   64'(satN),   64'd1);
        clearLanes();
        applyStimulus(0, 12'h000, 0, 1, "t2.accept");
        applyStimulus(1, 12'h0FF, 0, 0, "t3.start");
        checkVal("t3.satclr", 64'(satN), 64'd0);
        setAllLanes(12'h0FF, 16'hFFFF);
        applyStimulus(0, 12'h000, 0, 0, "t3.lane1");
        applyStimulus(0, 12'h000, 1, 0, "t3.lane2");
        checkVal("t3.npaths", 64'(pathsN), 64'h1FFFF);
        checkVal("t3.nsat",   64'(satN),   64'd1);
        clearLanes();
        applyStimulus(0, 12'h000, 0, 1, "t3.accept");

        // 4: invalid matching lane, and start+done together restarting the window.
        applyStimulus(1, 12'h020, 0, 0, "t4.start");
        reqNode[1] = 12'h020; reqPaths[1] = 16'd9;
        applyStimulus(0, 12'h000, 0, 0, "t4.invalid");
        reqVld[3] = 1'b1; reqNode[3] = 12'h020; reqPaths[3] = 16'd40;
        applyStimulus(1, 12'h010, 1, 0, "t4.restart");
        checkVal("t4.rdy",   64'(rdyW),   64'd1);
        checkVal("t4.paths", 64'(pathsW), 64'd0);
        clearLanes();
        reqNode[5] = 12'h010; reqPaths[5] = 16'd9;
        applyStimulus(0, 12'h000, 0, 0, "t4.invalid2");
        clearLanes();

        // 5: reset mid-window and in OUT; done in IDLE is ignored.
        reqVld[0] = 1'b1; reqNode[0] = 12'h010; reqPaths[0] = 16'd55;
        applyStimulus(0, 12'h000, 0, 0, "t5.accum");
        doReset("t5.rstaccum");
        applyStimulus(1, 12'h010, 0, 0, "t5.start");
        applyStimulus(0, 12'h000, 1, 0, "t5.done");
        clearLanes();
        doReset("t5.rstout");
        applyStimulus(0, 12'h000, 1, 0, "t5.idledone");
        checkVal("t5.novld", 64'(vldW), 64'd0);

        // 6: start in OUT is ignored until the result is accepted.
        applyStimulus(1, 12'h033, 0, 0, "t6.start");
        setAllLanes(12'h033, 16'd21);
        applyStimulus(0, 12'h000, 1, 0, "t6.done");
        clearLanes();
        applyStimulus(1, 12'h044, 0, 0, "t6.startout");
        checkVal("t6.busy",  64'(busyW),  64'd1);
        checkVal("t6.paths", 64'(pathsW), 64'd168);
        applyStimulus(0, 12'h000, 0, 1, "t6.accept");
        applyStimulus(1, 12'h044, 0, 0, "t6.b2b");

        // Randomized windows with stray starts, random back-pressure and idle gaps.
        for (int w = 0; w < 40; w++) begin
            logic [NW-1:0] tgt;
            int len;
            tgt = 12'($urandom_range(0, 15));
            clearLanes();
            applyStimulus(1, tgt, 0, 0, "rnd.start");
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                randomLanes(tgt);
                applyStimulus($urandom_range(0, 19) == 0, 12'($urandom_range(0, 15)),
                              c == len - 1, 1'($urandom_range(0, 1)), "rnd.accum");
            end
            for (int c = 0; c < 4; c++) begin
                randomLanes(tgt);
                applyStimulus($urandom_range(0, 3) == 0, 12'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), "rnd.drain");
            end
            if ($urandom_range(0, 9) == 0) doReset("rnd.rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
